// File: rtl/median_filter_ctrl.sv
// Frame controller for a streaming 2x2 median filter: paces upstream pixels,
// masks the first row/column, and holds each completed window until consumed.
module median_filter_ctrl #(
    parameter int unsigned IMAGE_LEN    = 1080,
    parameter int unsigned IMAGE_HEIGHT = 720
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic abort_i,
    input  logic src_valid_i,
    output logic src_ready_o,
    output logic filt_start_o,
    output logic filt_valid_o,
    output logic out_valid_o,
    input  logic dst_ready_i,
    output logic busy_o,
    output logic done_o
);

    localparam int unsigned COL_W     = $clog2(IMAGE_LEN);
    localparam int unsigned ROW_W     = $clog2(IMAGE_HEIGHT);
    localparam int unsigned OUT_TOTAL = (IMAGE_LEN - 1) * (IMAGE_HEIGHT - 1);
    localparam int unsigned OUT_W     = $clog2(OUT_TOTAL + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [COL_W-1:0] in_col;
    logic [ROW_W-1:0] in_row;
    logic [OUT_W-1:0] out_cnt;

    logic ready;
    logic accept;
    logic start_frame;
    logic abort_frame;
    logic col_last;
    logic row_last;
    logic mask_hit;
    logic out_hs;

    assign col_last    = (in_col == COL_W'(IMAGE_LEN - 1));
    assign row_last    = (in_row == ROW_W'(IMAGE_HEIGHT - 1));
    assign mask_hit    = (in_col != '0) && (in_row != '0);
    assign out_hs      = out_valid_o && dst_ready_i;
    assign abort_frame = abort_i && (state != IDLE);

    // Handshake pacing is combinational: a single output stage with no skid buffer.
    assign src_ready_o  = ready;
    assign filt_valid_o = accept;
    assign filt_start_o = start_frame && rst_n;

    // Next-state and handshake decode
    always_comb begin
        next_state  = state;
        ready       = 1'b0;
        accept      = 1'b0;
        start_frame = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i && !abort_i) begin
                    next_state  = RUN;
                    start_frame = 1'b1;
                end
            end
            RUN: begin
                ready  = !out_valid_o || dst_ready_i;
                accept = src_valid_i && ready;
                if (accept && col_last && row_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_o) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (abort_frame) begin
            next_state = IDLE;
        end
    end

    // State register with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= next_state;
            busy_o <= (next_state != IDLE);
            done_o <= (next_state == DONE);
        end
    end

    // Input raster position; wraps fully at frame end so it never overflows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_col <= '0;
            in_row <= '0;
        end else if (start_frame || abort_frame) begin
            in_col <= '0;
            in_row <= '0;
        end else if (accept) begin
            if (col_last) begin
                in_col <= '0;
                in_row <= row_last ? '0 : in_row + ROW_W'(1);
            end else begin
                in_col <= in_col + COL_W'(1);
            end
        end
    end

    // Output window flag: a new masked-in accept overrides a same-cycle handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
        end else if (abort_frame) begin
            out_valid_o <= 1'b0;
        end else if (accept && mask_hit) begin
            out_valid_o <= 1'b1;
        end else if (out_hs) begin
            out_valid_o <= 1'b0;
        end
    end

    // Outputs consumed this frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (start_frame || abort_frame) begin
            out_cnt <= '0;
        end else if (out_hs) begin
            out_cnt <= out_cnt + OUT_W'(1);
        end
    end

    a_hold_window: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid_o && !dst_ready_i && !abort_i |=> out_valid_o);

    a_accept_in_run: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> state == RUN);

    a_done_complete: assert property (@(posedge clk) disable iff (!rst_n)
        done_o |-> out_cnt == OUT_W'(OUT_TOTAL));

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Scoreboard bench for median_filter_ctrl: expected output pixel indices are
// queued per frame and matched against the accept index that loaded each window.
module tb_median_filter_ctrl;

    localparam int unsigned L = 4;
    localparam int unsigned H = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic start_i, abort_i, src_valid_i, dst_ready_i;
    logic src_ready_o, filt_start_o, filt_valid_o, out_valid_o, busy_o, done_o;

    logic start2, abort2, sv2, dr2;
    logic ready2, fs2, fv2, ov2, busy2, done2;

    always #5 clk = ~clk;

    median_filter_ctrl #(.IMAGE_LEN(L), .IMAGE_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
        .filt_start_o(filt_start_o), .filt_valid_o(filt_valid_o),
        .out_valid_o(out_valid_o), .dst_ready_i(dst_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    median_filter_ctrl #(.IMAGE_LEN(2), .IMAGE_HEIGHT(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .abort_i(abort2),
        .src_valid_i(sv2), .src_ready_o(ready2),
        .filt_start_o(fs2), .filt_valid_o(fv2),
        .out_valid_o(ov2), .dst_ready_i(dr2),
        .busy_o(busy2), .done_o(done2)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int acc, outs, dones, pend_id, prev_idx;
    bit prev_acc, prev_ov, prev_hs, track;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-cycle monitor, called mid-cycle on the falling edge
    task automatic sample();
        check("filt_valid", int'(filt_valid_o), int'(src_valid_i && src_ready_o));
        if (out_valid_o && !dst_ready_i) check("src_ready_bp", int'(src_ready_o), 0);
        if (track) begin
            if (prev_acc) begin
                if (out_valid_o) pend_id = prev_idx;
            end else begin
                check("ov_hold", int'(out_valid_o), int'(prev_ov && !prev_hs));
            end
            if (out_valid_o && dst_ready_i) begin
                outs++;
                if (exp_q.size() == 0) check("out_extra", int'(out_valid_o), 0);
                else check("out_idx", pend_id, exp_q.pop_front());
            end
            if (filt_valid_o) begin
                check("busy_run", int'(busy_o), 1);
                prev_idx = acc;
                acc++;
            end
            if (done_o) dones++;
        end
        prev_acc = filt_valid_o;
        prev_ov  = out_valid_o;
        prev_hs  = out_valid_o && dst_ready_i;
    endtask

    task automatic run_frame(input bit bubbly, input bit stall, input int abort_at,
                             input int rst_at, input bit start_in_done);
        int cyc;
        int stall_left;
        bit fin;
        exp_q.delete();
        for (int k = 0; k < int'(L * H); k++)
            if ((k % int'(L)) != 0 && (k / int'(L)) != 0) exp_q.push_back(k);
        acc = 0; outs = 0; dones = 0; pend_id = -1;
        prev_acc = 0; prev_ov = 0; prev_hs = 0; track = 0;

        @(posedge clk); #1;
        start_i = 1'b1; src_valid_i = 1'b0; dst_ready_i = 1'b1; abort_i = 1'b0;
        @(negedge clk);
        check("filt_start", int'(filt_start_o), 1);
        check("idle_ready", int'(src_ready_o), 0);
        @(posedge clk); #1;
        start_i = 1'b0;
        track = 1'b1;

        cyc = 0; stall_left = 3; fin = 1'b0;
        while (!fin && cyc < 400) begin
            src_valid_i = bubbly ? (cyc % 2 == 0) : 1'b1;
            dst_ready_i = 1'b1;
            if (stall && stall_left > 0 && out_valid_o) begin
                dst_ready_i = 1'b0;
                stall_left--;
            end
            abort_i = (abort_at >= 0 && acc == abort_at);
            @(negedge clk);
            sample();
            if (abort_i) begin
                fin = 1'b1;
            end else if (rst_at >= 0 && acc >= rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_ready", int'(src_ready_o), 0);
                check("rst_fstart", int'(filt_start_o), 0);
                check("rst_fvalid", int'(filt_valid_o), 0);
                check("rst_ovalid", int'(out_valid_o), 0);
                check("rst_busy", int'(busy_o), 0);
                check("rst_done", int'(done_o), 0);
                fin = 1'b1;
            end else if (done_o) begin
                fin = 1'b1;
                if (start_in_done) start_i = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("frame_end", int'(fin), 1);
        start_i = 1'b0; abort_i = 1'b0; src_valid_i = 1'b0; dst_ready_i = 1'b1;
        track = 1'b0;

        if (abort_at >= 0) begin
            @(negedge clk);
            check("abort_busy", int'(busy_o), 0);
            check("abort_ovalid", int'(out_valid_o), 0);
            check("abort_ready", int'(src_ready_o), 0);
            check("abort_outs", outs, 0);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("abort_no_done", int'(done_o), 0);
            end
        end else if (rst_at >= 0) begin
            rst_n = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("rst_no_done", int'(done_o), 0);
                check("rst_idle", int'(busy_o), 0);
            end
        end else begin
            @(negedge clk);
            check("done_pulse", int'(done_o), 0);
            check("busy_after", int'(busy_o), 0);
            check("accepts", acc, int'(L * H));
            check("outputs", outs, int'((L - 1) * (H - 1)));
            check("dones", dones, 1);
            check("q_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        int acc2, outs2, dones2, pend2, pidx2;
        bit pacc2;
        rst_n = 1'b0;
        start_i = 1'b0; abort_i = 1'b0; src_valid_i = 1'b1; dst_ready_i = 1'b1;
        start2 = 1'b0; abort2 = 1'b0; sv2 = 1'b0; dr2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", int'(src_ready_o), 0);
        check("reset_fstart", int'(filt_start_o), 0);
        check("reset_fvalid", int'(filt_valid_o), 0);
        check("reset_ovalid", int'(out_valid_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_done", int'(done_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        src_valid_i = 1'b0;

        run_frame(1'b0, 1'b0, -1, -1, 1'b0);       // continuous stream
        run_frame(1'b0, 1'b1, -1, -1, 1'b0);       // downstream stall
        run_frame(1'b1, 1'b0, -1, -1, 1'b1);       // bubbly source, start during DONE
        run_frame(1'b0, 1'b0, int'(L) + 1, -1, 1'b0);  // abort in row 1
        run_frame(1'b0, 1'b0, -1, -1, 1'b0);
        run_frame(1'b0, 1'b0, -1, 7, 1'b0);        // reset mid-frame
        run_frame(1'b0, 1'b0, -1, -1, 1'b0);

        // Minimum 2x2 image: only the last pixel completes a window
        acc2 = 0; outs2 = 0; dones2 = 0; pend2 = -1; pidx2 = -1; pacc2 = 1'b0;
        @(posedge clk); #1;
        start2 = 1'b1; sv2 = 1'b1; dr2 = 1'b1;
        @(negedge clk);
        check("s_fstart", int'(fs2), 1);
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int i = 0; i < 50 && dones2 == 0; i++) begin
            @(negedge clk);
            if (pacc2 && ov2) pend2 = pidx2;
            if (ov2 && dr2) begin
                outs2++;
                check("s_out_idx", pend2, 3);
            end
            if (fv2) begin
                pidx2 = acc2;
                acc2++;
            end
            pacc2 = fv2;
            if (done2) dones2++;
        end
        sv2 = 1'b0;
        check("s_accepts", acc2, 4);
        check("s_outputs", outs2, 1);
        check("s_dones", dones2, 1);
        @(negedge clk);
        check("s_busy_after", int'(busy2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
